id_ex_pipe_reg: RTL

Parametrised ID/EX pipeline register. It carries the decoded instruction, source operands, immediate and control bundle from decode to execute. A valid/ready handshake with a one-entry skid buffer lets execute back-pressure decode without a combinational ready path. It also provides bubble insertion, synchronous flush, and write-back refresh of held source operands while stalled.

---
 rtl/id_ex_pipe_reg_if.sv | 56 +++++
 rtl/id_ex_pipe_reg.sv | 139 +++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// Decode-to-execute bus for the ID/EX pipeline register: input beat, handshake,
// write-back snoop port and main-entry payload outputs.
interface id_ex_pipe_reg_if #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 3,
   parameter int ALU_CMD_W  = 3,
   parameter int NUM_SRC    = 2
);
   logic                           flush;
   logic                           bubble;
   logic                           in_valid;
   logic                           in_ready;
   logic [DATA_W-1:0]              inst;
   logic [NUM_SRC*REG_ADDR_W-1:0]  src_addr;
   logic [NUM_SRC*DATA_W-1:0]      src_data;
   logic [DATA_W-1:0]              imm_data;
   logic                           wr_en;
   logic                           alu_src2_sel_rf_imm;
   logic                           mem_store;
   logic                           wb_mem_select;
   logic [ALU_CMD_W-1:0]           alu_cmd;
   logic [REG_ADDR_W-1:0]          write_addr;
   logic                           wb_en;
   logic [REG_ADDR_W-1:0]          wb_addr;
   logic [DATA_W-1:0]              wb_data;
   logic                           out_valid;
   logic                           out_ready;
   logic [DATA_W-1:0]              inst_out;
   logic [NUM_SRC*REG_ADDR_W-1:0]  src_addr_out;
   logic [NUM_SRC*DATA_W-1:0]      src_data_out;
   logic [DATA_W-1:0]              imm_data_out;
   logic                           wr_en_out;
   logic                           alu_src2_sel_rf_imm_out;
   logic                           mem_store_out;
   logic                           wb_mem_select_out;
   logic [ALU_CMD_W-1:0]           alu_cmd_out;
   logic [REG_ADDR_W-1:0]          write_addr_out;

   modport master (
      output flush, bubble, in_valid, inst, src_addr, src_data, imm_data,
             wr_en, alu_src2_sel_rf_imm, mem_store, wb_mem_select, alu_cmd,
             write_addr, wb_en, wb_addr, wb_data, out_ready,
      input  in_ready, out_valid, inst_out, src_addr_out, src_data_out,
             imm_data_out, wr_en_out, alu_src2_sel_rf_imm_out, mem_store_out,
             wb_mem_select_out, alu_cmd_out, write_addr_out
   );

   modport slave (
      input  flush, bubble, in_valid, inst, src_addr, src_data, imm_data,
             wr_en, alu_src2_sel_rf_imm, mem_store, wb_mem_select, alu_cmd,
             write_addr, wb_en, wb_addr, wb_data, out_ready,
      output in_ready, out_valid, inst_out, src_addr_out, src_data_out,
             imm_data_out, wr_en_out, alu_src2_sel_rf_imm_out, mem_store_out,
             wb_mem_select_out, alu_cmd_out, write_addr_out
   );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with a one-entry skid buffer so in_ready is purely
// registered, plus bubble, flush and write-back refresh of held operands.
module id_ex_pipe_reg #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 3,
   parameter int ALU_CMD_W  = 3,
   parameter int NUM_SRC    = 2,
   parameter int FWD_EN     = 1
) (
   input logic            clk,
   input logic            rst,
   id_ex_pipe_reg_if.slave bus
);

   typedef struct packed {
      logic [DATA_W-1:0]             inst;
      logic [NUM_SRC*REG_ADDR_W-1:0] src_addr;
      logic [NUM_SRC*DATA_W-1:0]     src_data;
      logic [DATA_W-1:0]             imm_data;
      logic                          wr_en;
      logic                          alu_src2_sel_rf_imm;
      logic                          mem_store;
      logic                          wb_mem_select;
      logic [ALU_CMD_W-1:0]          alu_cmd;
      logic [REG_ADDR_W-1:0]         write_addr;
   } entry_t;

   entry_t main_q, main_d, skid_q, skid_d, in_beat;
   logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic   accept, fire, main_free;

   // Replace every operand whose source register is being written back now.
   function automatic entry_t refresh(input entry_t e, input logic en,
                                      input logic [REG_ADDR_W-1:0] addr,
                                      input logic [DATA_W-1:0] data);
      entry_t r;
      r = e;
      if (FWD_EN != 0 && en) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (e.src_addr[i*REG_ADDR_W +: REG_ADDR_W] == addr)
               r.src_data[i*DATA_W +: DATA_W] = data;
         end
      end
      return r;
   endfunction

   function automatic entry_t clear_ctrl(input entry_t e);
      entry_t r;
      r = e;
      r.wr_en               = 1'b0;
      r.alu_src2_sel_rf_imm = 1'b0;
      r.mem_store           = 1'b0;
      r.wb_mem_select       = 1'b0;
      return r;
   endfunction

   assign accept    = bus.in_valid && !skid_valid_q && !bus.flush;
   assign fire      = main_valid_q && bus.out_ready;
   assign main_free = !main_valid_q || fire;

   always_comb begin
      in_beat.inst                = bus.inst;
      in_beat.src_addr            = bus.src_addr;
      in_beat.src_data            = bus.src_data;
      in_beat.imm_data            = bus.imm_data;
      in_beat.wr_en               = bus.wr_en;
      in_beat.alu_src2_sel_rf_imm = bus.alu_src2_sel_rf_imm;
      in_beat.mem_store           = bus.mem_store;
      in_beat.wb_mem_select       = bus.wb_mem_select;
      in_beat.alu_cmd             = bus.alu_cmd;
      in_beat.write_addr          = bus.write_addr;
      if (bus.bubble)
         in_beat = clear_ctrl(in_beat);
      in_beat = refresh(in_beat, bus.wb_en, bus.wb_addr, bus.wb_data);
   end

   // Flush wins; otherwise skid drains into main before any new beat is taken.
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (bus.flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         main_d       = clear_ctrl(main_q);
         skid_d       = clear_ctrl(skid_q);
      end else begin
         if (main_free) begin
            if (skid_valid_q) begin
               main_d       = refresh(skid_q, bus.wb_en, bus.wb_addr, bus.wb_data);
               main_valid_d = 1'b1;
               skid_valid_d = 1'b0;
            end else if (accept) begin
               main_d       = in_beat;
               main_valid_d = 1'b1;
            end else begin
               main_valid_d = 1'b0;
            end
         end else begin
            main_d = refresh(main_q, bus.wb_en, bus.wb_addr, bus.wb_data);
            if (accept) begin
               skid_d       = in_beat;
               skid_valid_d = 1'b1;
            end else if (skid_valid_q) begin
               skid_d = refresh(skid_q, bus.wb_en, bus.wb_addr, bus.wb_data);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign bus.in_ready                = !skid_valid_q;
   assign bus.out_valid               = main_valid_q;
   assign bus.inst_out                = main_q.inst;
   assign bus.src_addr_out            = main_q.src_addr;
   assign bus.src_data_out            = main_q.src_data;
   assign bus.imm_data_out            = main_q.imm_data;
   assign bus.wr_en_out               = main_q.wr_en;
   assign bus.alu_src2_sel_rf_imm_out = main_q.alu_src2_sel_rf_imm;
   assign bus.mem_store_out           = main_q.mem_store;
   assign bus.wb_mem_select_out       = main_q.wb_mem_select;
   assign bus.alu_cmd_out             = main_q.alu_cmd;
   assign bus.write_addr_out          = main_q.write_addr;

endmodule
